// File: rtl/sseg_compare_scan.sv
// rtl/sseg_compare_scan.sv - 2-bit magnitude comparator with a multiplexed 3-digit seven-segment scan.
// Shows a on the left digit, b in the middle and a G/L/E letter on the right, with blank gaps between digits.
module sseg_compare_scan #(
   parameter int SCAN_DIV  = 12000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       load,
   output logic       valid,
   output logic       a_gt_b,
   output logic       a_lt_b,
   output logic       a_eq_b,
   output logic [2:0] sseg_en,
   output logic [7:0] sseg
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_G     = 8'b01000011;
   localparam logic [7:0] SEG_L     = 8'b11100011;
   localparam logic [7:0] SEG_E     = 8'b01100001;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHOW2 = 3'd1,
      GAP2  = 3'd2,
      SHOW1 = 3'd3,
      GAP1  = 3'd4,
      SHOW0 = 3'd5,
      GAP0  = 3'd6
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt;
   logic [1:0]    a_r, b_r;
   logic [2:0]    en_d;
   logic [7:0]    seg_d;

   function automatic logic [7:0] digit_code(input logic [1:0] d);
      case (d)
         2'd0:    digit_code = 8'b00000011;
         2'd1:    digit_code = 8'b10011111;
         2'd2:    digit_code = 8'b00100101;
         default: digit_code = 8'b00001101;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= 2'd0;
         b_r   <= 2'd0;
         valid <= 1'b0;
      end else if (load) begin
         a_r   <= a;
         b_r   <= b;
         valid <= 1'b1;
      end
   end

   // Flags stay cleared until the first capture has landed in a_r/b_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_gt_b <= 1'b0;
         a_lt_b <= 1'b0;
         a_eq_b <= 1'b0;
      end else if (valid) begin
         a_gt_b <= (a_r > b_r);
         a_lt_b <= (a_r < b_r);
         a_eq_b <= (a_r == b_r);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= (state_d != state) ? '0 : cnt + CW'(1);
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (valid)            state_d = SHOW2;
         SHOW2:   if (cnt == SHOW_LAST) state_d = GAP2;
         GAP2:    if (cnt == GAP_LAST)  state_d = SHOW1;
         SHOW1:   if (cnt == SHOW_LAST) state_d = GAP1;
         GAP1:    if (cnt == GAP_LAST)  state_d = SHOW0;
         SHOW0:   if (cnt == SHOW_LAST) state_d = GAP0;
         GAP0:    if (cnt == GAP_LAST)  state_d = SHOW2;
         default:                       state_d = IDLE;
      endcase
   end

   always_comb begin
      en_d  = 3'b111;
      seg_d = SEG_BLANK;
      case (state)
         SHOW2: begin
            en_d  = 3'b011;
            seg_d = digit_code(a_r);
         end
         SHOW1: begin
            en_d  = 3'b101;
            seg_d = digit_code(b_r);
         end
         SHOW0: begin
            en_d  = 3'b110;
            seg_d = a_gt_b ? SEG_G : (a_lt_b ? SEG_L : SEG_E);
         end
         default: begin
            en_d  = 3'b111;
            seg_d = SEG_BLANK;
         end
      endcase
   end

   // Registered drive keeps the pads glitch-free; reset blanks them without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sseg_en <= 3'b111;
         sseg    <= SEG_BLANK;
      end else begin
         sseg_en <= en_d;
         sseg    <= seg_d;
      end
   end

endmodule

// File: tb/tb_sseg_compare_scan.sv
// tb/tb_sseg_compare_scan.sv - randomized bench for sseg_compare_scan against a timeline reference model.
module tb_sseg_compare_scan;

   localparam int SD  = 4;
   localparam int BC  = 2;
   localparam int PER = 3 * (SD + BC);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] a = 2'd0;
   logic [1:0] b = 2'd0;
   logic       load = 1'b0;
   logic       valid, a_gt_b, a_lt_b, a_eq_b;
   logic [2:0] sseg_en;
   logic [7:0] sseg;

   int checks = 0;
   int failures = 0;

   // Model state: register values after this edge (x0), previous edge (x1), two edges ago (x2).
   logic [1:0] m_a0, m_a1, m_a2, m_b0, m_b1, m_b2;
   logic       m_v0, m_v1;
   bit         started;
   int         k;

   sseg_compare_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .load(load),
      .valid(valid), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
      .sseg_en(sseg_en), .sseg(sseg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] dig(input logic [1:0] d);
      logic [7:0] tbl [4];
      tbl[0] = 8'b00000011;
      tbl[1] = 8'b10011111;
      tbl[2] = 8'b00100101;
      tbl[3] = 8'b00001101;
      return tbl[d];
   endfunction

   function automatic logic [2:0] cmp3(input logic [1:0] x, input logic [1:0] y);
      int xi = int'(x);
      int yi = int'(y);
      return {xi > yi, xi < yi, xi == yi};
   endfunction

   function automatic logic [7:0] letter(input logic [1:0] x, input logic [1:0] y);
      int xi = int'(x);
      int yi = int'(y);
      if (xi > yi) return 8'b01000011;
      if (xi < yi) return 8'b11100011;
      return 8'b01100001;
   endfunction

   function automatic int phase();
      if (!started || k < 2) return -1;
      return (k - 2) % PER;
   endfunction

   task automatic model_reset();
      m_a0 = 0; m_a1 = 0; m_a2 = 0;
      m_b0 = 0; m_b1 = 0; m_b2 = 0;
      m_v0 = 0; m_v1 = 0;
      started = 0;
      k = 0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else begin
         m_a2 = m_a1; m_a1 = m_a0;
         m_b2 = m_b1; m_b1 = m_b0;
         m_v1 = m_v0;
         if (started) k++;
         if (load) begin
            m_a0 = a;
            m_b0 = b;
            m_v0 = 1'b1;
            if (!started) begin
               started = 1;
               k = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      int p;
      logic [2:0] e_en;
      logic [7:0] e_seg;
      p = phase();
      e_en = 3'b111;
      e_seg = 8'hFF;
      if (p >= 0 && p < SD) begin
         e_en = 3'b011; e_seg = dig(m_a1);
      end else if (p >= SD + BC && p < 2 * SD + BC) begin
         e_en = 3'b101; e_seg = dig(m_b1);
      end else if (p >= 2 * (SD + BC) && p < 3 * SD + 2 * BC) begin
         e_en = 3'b110; e_seg = letter(m_a2, m_b2);
      end
      check("valid", valid, m_v0);
      check("flags", {a_gt_b, a_lt_b, a_eq_b}, m_v1 ? cmp3(m_a1, m_b1) : 3'b000);
      check("sseg_en", sseg_en, e_en);
      check("sseg", sseg, e_seg);
      check("one_digit", $countones(~sseg_en) <= 1, 1);
      if (valid && m_v1) check("flag_onehot", $countones({a_gt_b, a_lt_b, a_eq_b}), 1);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_load(input logic [1:0] av, input logic [1:0] bv);
      a = av; b = bv; load = 1'b1;
      cycle();
      load = 1'b0;
   endtask

   task automatic wait_phase(input int target, input string tag);
      int n = 0;
      while (phase() != target && n < 3 * PER) begin
         cycle();
         n++;
      end
      if (phase() != target) check(tag, 0, 1);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      run(3);
      @(negedge clk);
      rst_n = 1'b1;

      run(50);

      do_load(2'd2, 2'd1);
      run(2 * PER + 4);

      do_load(2'd1, 2'd3);
      run(PER);
      wait_phase(2 * (SD + BC) + 1, "wait_show0");
      do_load(2'd3, 2'd3);
      run(PER + 4);

      for (int i = 0; i < 16; i++) begin
         do_load(2'(i >> 2), 2'(i & 3));
         run(PER + 2);
      end

      for (int i = 0; i < 400; i++) begin
         a = 2'($urandom_range(0, 3));
         b = 2'($urandom_range(0, 3));
         load = (i % 100 < 30) ? 1'b1 : ($urandom_range(0, 5) == 0);
         cycle();
      end
      load = 1'b0;

      wait_phase(SD + BC + 2, "wait_show1");
      #2 rst_n = 1'b0;
      #1;
      check("async_en", sseg_en, 3'b111);
      check("async_seg", sseg, 8'hFF);
      check("async_valid", valid, 0);
      check("async_flags", {a_gt_b, a_lt_b, a_eq_b}, 3'b000);
      model_reset();
      #1 rst_n = 1'b1;
      run(30);
      do_load(2'd0, 2'd2);
      run(2 * PER);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sseg_compare_scan.md
SSEG_COMPARE_SCAN -- requirements
Module: sseg_compare_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12000, clock cycles each digit is driven (1 kHz per digit at 12 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 16, all-digits-off cycles between digits (anti-ghosting); legal range 1..SCAN_DIV.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port a  input  2  operand A.
REQ-006 SHALL have port b  input  2  operand B.
REQ-007 SHALL have port load  input  1  sample-request; high for one or more cycles captures a, b each cycle high.
REQ-008 SHALL have port valid  output  1  high once at least one load has been captured.
REQ-009 SHALL have ports a_gt_b, a_lt_b, a_eq_b  output  1 each  registered compare flags; mutually exclusive.
REQ-010 SHALL have port sseg_en  output  3  digit enables, active-low; [2]=left, [1]=middle, [0]=right.
REQ-011 SHALL have port sseg  output  8  segments active-low, bit order {a,b,c,d,e,f,g,dp}.

Function
REQ-012 SHALL capture a, b into a_r, b_r at the rising edge where load=1; valid SHALL go high at that same edge.
REQ-013 SHALL update a_gt_b/a_lt_b/a_eq_b one edge after capture (latency 1 from load edge), unsigned compare of a_r vs b_r.
REQ-014 SHALL implement FSM states IDLE, SHOW2, GAP2, SHOW1, GAP1, SHOW0, GAP0.
REQ-015 IDLE: sseg_en=3'b111, sseg=8'hFF; SHALL leave IDLE to SHOW2 on the first edge with valid=1.
REQ-016 SHOWn: SHALL last exactly SCAN_DIV cycles with only sseg_en[n]=0, then go to GAPn.
REQ-017 GAPn: SHALL last exactly BLANK_CYC cycles with sseg_en=3'b111, sseg=8'hFF; GAP2->SHOW1, GAP1->SHOW0, GAP0->SHOW2 (wrap).
REQ-018 SHALL use one cycle counter, cleared on each state change; full period = 3*(SCAN_DIV+BLANK_CYC) cycles.
REQ-019 SHOW2 SHALL drive digit of a_r; SHOW1 digit of b_r; SHOW0 letter of current flags.
REQ-020 Digit codes SHALL be 0=8'b00000011, 1=8'b10011111, 2=8'b00100101, 3=8'b00001101; dp always off.
REQ-021 Letter codes SHALL be G=8'b01000011 (gt), L=8'b11100011 (lt), E=8'b01100001 (eq).
REQ-022 sseg and sseg_en SHALL be registered; they change only on clk edges, one cycle after state/data change.
REQ-023 load during any SHOW state SHALL NOT disturb state or counter; new value appears on the active digit within 2 cycles (flags digit within 3).
REQ-024 Sustained load SHALL track inputs every cycle; scan timing unaffected.
REQ-025 After valid=1 the FSM SHALL never return to IDLE except via reset.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state=IDLE, counter=0, a_r=b_r=0, valid=0, all flags 0, sseg_en=3'b111, sseg=8'hFF.
REQ-027 Reset asserted mid-scan SHALL blank the display immediately, without waiting for a clock edge.
REQ-028 First edge after rst_n rises SHALL be treated normally (load on that edge is captured).

Verification (bench uses SCAN_DIV=4, BLANK_CYC=2)
REQ-029 Reset, no load for 50 cycles -> valid=0, flags all 0, sseg_en=111, sseg=FF throughout.
REQ-030 load a=2,b=1 one cycle -> next edge a_gt_b=1; left digit 00100101 for 4 cycles, 2 blank, middle 10011111, 2 blank, right 01000011; period 18 cycles.
REQ-031 a=1,b=3 load -> a_lt_b=1, right digit 11100011; then a=3,b=3 load mid-SHOW0 -> within 3 cycles right digit 01100001, counter timing unchanged.
REQ-032 Exhaustive 16 a/b pairs via load -> exactly one flag high, matching unsigned compare, correct digit codes each.
REQ-033 rst_n pulsed low mid-SHOW1, between edges -> sseg_en=111, sseg=FF, valid=0 asynchronously; scan resumes from SHOW2 only after next load.
REQ-034 Assertions: never more than one sseg_en bit low; flags one-hot when valid=1.
